// File: rtl/shift_feeder.sv
// shift_feeder: byte sequencer feeding an 8-bit parallel-load shift register.
// Bytes arrive over a valid/ready handshake into a DEPTH-entry FIFO. Each byte
// is presented on pdata with a one-cycle load pulse, followed by eight shift
// cycles, so the register emits pdata[0] first on its sout. Bytes follow each
// other with no idle cycles.
//
// Ports:
//   clk        rising-edge clock shared with the shift register
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort of FIFO contents and the byte in flight
//   in_data    byte to send, bit 0 transmitted first
//   in_valid   in_data valid
//   in_ready   registered, FIFO can accept this cycle
//   pdata      to register datain, holds the current byte
//   load       to register shift_load, one cycle per byte
//   serial     to register serial input, constant 0 fill
//   bit_valid  register sout carries a data bit this cycle
//   byte_done  pulse on the last bit cycle of a byte
//   busy       FSM not idle or FIFO non-empty
module shift_feeder #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] pdata,
    output logic       load,
    output logic       serial,
    output logic       bit_valid,
    output logic       byte_done,
    output logic       busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_idx_next;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            push;
    logic            pop;
    logic            fifo_nempty;

    logic            load_next;
    logic            bit_valid_next;
    logic            byte_done_next;
    logic            busy_next;

    assign push        = in_valid && in_ready && !flush;
    assign fifo_nempty = (count != '0);
    assign serial      = 1'b0;

    // Next state; a pop happens exactly on the edge that enters LOAD.
    always_comb begin
        state_next   = state;
        bit_idx_next = bit_idx;
        pop          = 1'b0;
        if (flush) begin
            state_next   = S_IDLE;
            bit_idx_next = 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fifo_nempty) begin
                        state_next = S_LOAD;
                        pop        = 1'b1;
                    end
                end
                S_LOAD: begin
                    state_next   = S_SHIFT;
                    bit_idx_next = 3'd0;
                end
                S_SHIFT: begin
                    if (bit_idx != 3'd7) begin
                        bit_idx_next = bit_idx + 3'd1;
                    end else begin
                        bit_idx_next = 3'd0;
                        if (fifo_nempty) begin
                            state_next = S_LOAD;
                            pop        = 1'b1;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_next   = S_IDLE;
                    bit_idx_next = 3'd0;
                end
            endcase
        end
        count_next = flush ? '0 : (count + CW'(push) - CW'(pop));
    end

    // Outputs decoded from the next state so they leave flops glitch-free.
    always_comb begin
        load_next      = (state_next == S_LOAD);
        bit_valid_next = (state_next == S_SHIFT);
        byte_done_next = (state_next == S_SHIFT) && (bit_idx_next == 3'd7);
        busy_next      = (state_next != S_IDLE) || (count_next != '0);
    end

    // State, control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            bit_idx   <= 3'd0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            in_ready  <= 1'b0;
            pdata     <= 8'h00;
            load      <= 1'b0;
            bit_valid <= 1'b0;
            byte_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            bit_idx   <= bit_idx_next;
            count     <= count_next;
            in_ready  <= (count_next < CW'(DEPTH));
            load      <= load_next;
            bit_valid <= bit_valid_next;
            byte_done <= byte_done_next;
            busy      <= busy_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                    pdata  <= mem[rd_ptr];
                end
            end
        end
    end

    // FIFO storage, no reset needed: entries are only read after a push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: doc/shift_feeder.md
# shift_feeder

Upstream sequencer for the 8-bit parallel-load shift register. It accepts bytes over a valid/ready handshake into a small FIFO. For each byte it drives the register's `datain`, `shift_load` and `serial` inputs, so the byte leaves on `sout` index 0 first, one bit per clock, back-to-back with no idle cycles. It also flags which cycles carry a data bit on `sout`.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `clk`  in  1  rising-edge clock, shared with the shift register.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous abort: drop FIFO contents and the byte in flight.
- `in_data`  in  8  byte to send; bit [0] is transmitted first.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  registered; FIFO can accept this cycle.
- `pdata`  out  8  to register `datain`.
- `load`  out  1  to register `shift_load`; registered, glitch-free.
- `serial`  out  1  to register `serial`; constant 0 fill bit.
- `bit_valid`  out  1  high in cycles where register `sout` carries a data bit.
- `byte_done`  out  1  one-cycle pulse on a byte's last bit cycle.
- `busy`  out  1  high when state is not IDLE or the FIFO is non-empty.

## Operation
- **FIFO push:** on `in_valid && in_ready && !flush` at a clock edge.
- **`in_ready`:** registered as `next_count < DEPTH`. There is no same-cycle bypass when full.
- **FIFO pop:** on the edge that enters LOAD. The head byte is registered into `pdata`.
- **`pdata`:** holds that byte until the next LOAD.
- **FSM states:** IDLE, LOAD, SHIFT. A 3-bit counter `bit_idx` runs in SHIFT.
  - IDLE → LOAD when the FIFO is non-empty.
  - LOAD → SHIFT always, with `bit_idx` = 0.
  - SHIFT with `bit_idx` < 7 → SHIFT, `bit_idx`+1.
  - SHIFT with `bit_idx` = 7 → LOAD if the FIFO is non-empty, else IDLE.
- **Outputs by state:**
  - `load` = 1 only in LOAD.
  - `bit_valid` = 1 only in SHIFT.
  - `byte_done` = 1 in SHIFT with `bit_idx` = 7.
- **Register view:**
  - The rising `load` asynchronously loads `pdata`.
  - The edge leaving LOAD reloads it, since `load` is still high at that edge.
  - Each SHIFT edge after that shifts left, filling with `serial` = 0.
  - Result: `sout` = `pdata[i]` during SHIFT cycle `bit_idx` = i.
  - `sout` shows `pdata[0]` early during LOAD; `bit_valid` = 0 there.
- **`flush`:** sampled at an edge, it has priority over push and pop.
  - Next cycle: FIFO empty, state IDLE, `load`/`bit_valid`/`byte_done` = 0.
  - No `byte_done` is issued for an aborted byte.
  - `pdata` keeps its value.
- **Reset (`rst_n` low):** takes effect immediately, including mid-byte.
  - FIFO empty, state IDLE, `bit_idx` = 0.
  - All outputs 0: `pdata` = 0x00, `load` = 0, `in_ready` = 0.
- **After reset release:** `in_ready` rises at the first clock edge.

## Timing
- **Accept-to-load latency:** a byte accepted at edge T into an empty FIFO with the FSM in IDLE gives `load` = 1 in the cycle after edge T+1.
- **Byte period:** 9 cycles, 1 LOAD + 8 SHIFT. Consecutive bytes are back-to-back: `load` pulses exactly 9 cycles apart.
- **Last bit:** `byte_done` coincides with the `pdata[7]` cycle. `busy` falls the cycle after it if the FIFO is empty.
- **Throughput:** 8 data bits per 9 cycles.
- **Full FIFO:** `in_valid` held high while `in_ready` = 0 is ignored; no data is lost or duplicated.
- **Empty-from-idle fill:** continuous pushes are accepted for DEPTH+1 edges, because one pop occurs at the first LOAD.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-SHIFT → outputs immediately 0 (`pdata` = 0x00, `in_ready` = 0). After release, `in_ready` = 1 at the first edge and `busy` = 0.
- **Single byte 0xA5**, `pdata[0]` = 1, pushed at edge T:
  - `load` is high only in the cycle after T+1.
  - A reference shift-register model gives `sout` = 1,0,1,0,0,1,0,1 over the 8 `bit_valid` cycles.
  - `byte_done` fires on the 8th; `busy` drops the next cycle.
- **Back-to-back bytes 0x01, 0x80, 0xFF, 0x00:**
  - 4 `load` pulses 9 cycles apart; 32 contiguous-by-byte `bit_valid` bits match the model.
  - 4 `byte_done` pulses.
- **Full FIFO, DEPTH = 4:** hold `in_valid` from idle.
  - Exactly 5 bytes accepted, then `in_ready` = 0.
  - `in_ready` reasserts the cycle after the next pop.
  - All 5 bytes emerge in order.
- **Flush** in the 3rd `bit_valid` cycle with 2 bytes queued and `in_valid` = 1:
  - Next cycle `bit_valid` = 0, `load` = 0, `busy` = 0; no `byte_done`; the push is dropped.
  - A later push of 0x3C transmits correctly.
- **Simultaneous push and pop:** FIFO count = 1 at a SHIFT `bit_idx` = 7 edge with `in_valid` = 1 → count stays 1, LOAD follows immediately, ordering is preserved.
